// File: rtl/icc_cnt_rx.sv
`default_nettype none
// ============================================================================
//  Module   : icc_cnt_rx
//  Purpose  : Receive side of the ICC counter link. Deframes 48-bit timestamp
//             frames from the 16-bit GT word stream, computes the offset to
//             the local counter (plus link delay), qualifies it over repeated
//             frames and reports frame/error statistics.
//  Revision : 1.0  initial release
// ============================================================================
module icc_cnt_rx #(
  parameter int                DWIDTH  = 16,
  parameter logic [DWIDTH-1:0] HDR     = 16'h5cbc,
  parameter int                LOCKCNT = 8,
  parameter int                ERRMAX  = 4
) (
  input  logic              clk_i,
  input  logic              sreset_i,
  input  logic [DWIDTH-1:0] rxdata_i,
  input  logic              rxisk_i,
  input  logic              rxvalid_i,
  input  logic [47:0]       localcnt_i,
  input  logic [47:0]       linkdly_i,
  output logic [47:0]       corr48_o,
  output logic              usecorr_o,
  output logic              stb_corr_o,
  output logic [47:0]       offset_o,
  output logic [15:0]       framecnt_o,
  output logic [15:0]       errcnt_o
);

  localparam int AW = $clog2(LOCKCNT + 1);
  localparam int MW = $clog2(ERRMAX + 1);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_W2   = 3'd1,
    S_W1   = 3'd2,
    S_W0   = 3'd3,
    S_CK   = 3'd4
  } state_t;

  state_t            state_q;
  logic [DWIDTH-1:0] w2_q, w1_q, w0_q;
  logic [47:0]       lcap_q;
  logic [47:0]       offset_q, offset_d;
  logic [47:0]       corr48_q, corr48_d;
  logic              usecorr_q, usecorr_d;
  logic              stb_q;
  logic [15:0]       framecnt_q;
  logic [15:0]       errcnt_q, errcnt_inc;
  logic [AW-1:0]     agree_q, agree_d;
  logic [MW-1:0]     mism_q, mism_d;
  logic              ck_ok;
  logic              hdr_hit;

  assign ck_ok      = (rxdata_i == (w2_q ^ w1_q ^ w0_q));
  assign hdr_hit    = rxisk_i && (rxdata_i == HDR);
  assign errcnt_inc = (errcnt_q == 16'hffff) ? errcnt_q : errcnt_q + 16'd1;

  // Qualification next-state, valid only when the CK word completes a good frame
  always_comb begin
    offset_d  = {w2_q, w1_q, w0_q} + linkdly_i - lcap_q;
    agree_d   = '0;
    usecorr_d = usecorr_q;
    corr48_d  = corr48_q;
    mism_d    = mism_q;
    if (offset_d == offset_q) begin
      agree_d = (agree_q == AW'(LOCKCNT)) ? agree_q : agree_q + 1'b1;
    end
    if (!usecorr_q) begin
      // LOCKCNT identical offsets in a row (agree counts repeats, not frames)
      if (agree_d >= AW'(LOCKCNT - 1)) begin
        usecorr_d = 1'b1;
        corr48_d  = offset_d;
        mism_d    = '0;
      end
    end else if (offset_d == corr48_q) begin
      mism_d = '0;
    end else if (mism_q == MW'(ERRMAX - 1)) begin
      // Lock lost: requalify starting from this frame's offset
      usecorr_d = 1'b0;
      agree_d   = '0;
      mism_d    = '0;
    end else begin
      mism_d = mism_q + 1'b1;
    end
  end

  // Deframing FSM with offset datapath and statistics registers
  always_ff @(posedge clk_i) begin
    if (sreset_i) begin
      state_q    <= S_HUNT;
      w2_q       <= '0;
      w1_q       <= '0;
      w0_q       <= '0;
      lcap_q     <= '0;
      offset_q   <= '0;
      corr48_q   <= '0;
      usecorr_q  <= 1'b0;
      stb_q      <= 1'b0;
      framecnt_q <= '0;
      errcnt_q   <= '0;
      agree_q    <= '0;
      mism_q     <= '0;
    end else begin
      stb_q <= 1'b0;
      if (rxvalid_i) begin
        case (state_q)
          S_HUNT: begin
            if (hdr_hit) begin
              lcap_q  <= localcnt_i;
              state_q <= S_W2;
            end
          end
          default: begin
            if (rxisk_i) begin
              // K-character inside a frame aborts it; a header resyncs at once
              errcnt_q <= errcnt_inc;
              if (hdr_hit) begin
                lcap_q  <= localcnt_i;
                state_q <= S_W2;
              end else begin
                state_q <= S_HUNT;
              end
            end else begin
              case (state_q)
                S_W2: begin
                  w2_q    <= rxdata_i;
                  state_q <= S_W1;
                end
                S_W1: begin
                  w1_q    <= rxdata_i;
                  state_q <= S_W0;
                end
                S_W0: begin
                  w0_q    <= rxdata_i;
                  state_q <= S_CK;
                end
                default: begin
                  state_q <= S_HUNT;
                  if (ck_ok) begin
                    stb_q      <= 1'b1;
                    offset_q   <= offset_d;
                    framecnt_q <= framecnt_q + 16'd1;
                    agree_q    <= agree_d;
                    mism_q     <= mism_d;
                    usecorr_q  <= usecorr_d;
                    corr48_q   <= corr48_d;
                  end else begin
                    errcnt_q <= errcnt_inc;
                  end
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  assign corr48_o   = corr48_q;
  assign usecorr_o  = usecorr_q;
  assign stb_corr_o = stb_q;
  assign offset_o   = offset_q;
  assign framecnt_o = framecnt_q;
  assign errcnt_o   = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_icc_cnt_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icc_cnt_rx
//  Purpose  : Self-checking bench for icc_cnt_rx. Frames are built as
//             transactions; a frame-level reference model predicts offset,
//             qualification state and statistics after every frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icc_cnt_rx;

  localparam logic [15:0] HDR = 16'h5cbc;
  localparam int LOCKCNT = 8;
  localparam int ERRMAX  = 4;

  logic        clk_i = 1'b0;
  logic        sreset_i;
  logic [15:0] rxdata_i;
  logic        rxisk_i;
  logic        rxvalid_i;
  logic [47:0] localcnt_i;
  logic [47:0] linkdly_i;
  logic [47:0] corr48_o;
  logic        usecorr_o;
  logic        stb_corr_o;
  logic [47:0] offset_o;
  logic [15:0] framecnt_o;
  logic [15:0] errcnt_o;

  always #5 clk_i = ~clk_i;

  icc_cnt_rx #(
    .DWIDTH (16),
    .HDR    (HDR),
    .LOCKCNT(LOCKCNT),
    .ERRMAX (ERRMAX)
  ) u_dut (
    .clk_i     (clk_i),
    .sreset_i  (sreset_i),
    .rxdata_i  (rxdata_i),
    .rxisk_i   (rxisk_i),
    .rxvalid_i (rxvalid_i),
    .localcnt_i(localcnt_i),
    .linkdly_i (linkdly_i),
    .corr48_o  (corr48_o),
    .usecorr_o (usecorr_o),
    .stb_corr_o(stb_corr_o),
    .offset_o  (offset_o),
    .framecnt_o(framecnt_o),
    .errcnt_o  (errcnt_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state (frame level)
  logic [47:0] m_prev, m_corr;
  int          m_agree, m_mism, m_frames, m_errs;
  bit          m_lock;
  bit          exp_stb;

  task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_corr = '0; m_agree = 0; m_mism = 0;
    m_frames = 0; m_errs = 0; m_lock = 1'b0;
  endtask

  task automatic model_err();
    if (m_errs < 65535) m_errs++;
  endtask

  task automatic model_good(input logic [47:0] off);
    if (off == m_prev) m_agree = (m_agree + 1 > LOCKCNT) ? LOCKCNT : m_agree + 1;
    else               m_agree = 0;
    m_prev   = off;
    m_frames = (m_frames + 1) % 65536;
    if (!m_lock) begin
      if (m_agree >= LOCKCNT - 1) begin
        m_lock = 1'b1;
        m_corr = off;
        m_mism = 0;
      end
    end else if (off == m_corr) begin
      m_mism = 0;
    end else begin
      m_mism++;
      if (m_mism == ERRMAX) begin
        m_lock = 1'b0; m_agree = 0; m_mism = 0;
      end
    end
  endtask

  // One clock: drive at negedge, DUT samples at posedge, check at next negedge
  task automatic cyc(input logic [15:0] d, input logic k, input logic v);
    rxdata_i  = d;
    rxisk_i   = k;
    rxvalid_i = v;
    @(posedge clk_i);
    @(negedge clk_i);
    localcnt_i = localcnt_i + 48'd1;
    check_eq("stb_corr", {47'd0, stb_corr_o}, {47'd0, exp_stb});
    exp_stb = 1'b0;
  endtask

  task automatic gap(input int maxgap, input bit fixed);
    int n;
    n = fixed ? maxgap : int'($urandom_range(0, maxgap));
    repeat (n) cyc(16'($urandom), 1'($urandom), 1'b0);
  endtask

  // Line noise between frames: anything except a valid header
  task automatic idle(input int n);
    logic [15:0] d;
    logic k, v;
    repeat (n) begin
      d = 16'($urandom); k = 1'($urandom); v = 1'($urandom);
      if (k && v && d == HDR) d = ~HDR;
      cyc(d, k, v);
    end
  endtask

  task automatic check_outs(input string tag);
    check_eq({tag, "_offset"},   offset_o,             m_prev);
    check_eq({tag, "_corr48"},   corr48_o,             m_corr);
    check_eq({tag, "_usecorr"},  {47'd0, usecorr_o},   {47'd0, m_lock});
    check_eq({tag, "_framecnt"}, {32'd0, framecnt_o},  48'(m_frames));
    check_eq({tag, "_errcnt"},   {32'd0, errcnt_o},    48'(m_errs));
  endtask

  // abort_kind: 0 none, 1 header resync after W2, 2 non-header K after W1
  task automatic send_frame(input logic [47:0] rel, input bit bad_ck, input int maxgap,
                            input bit fixed_gap, input int abort_kind);
    logic [47:0] lcap, cnt, off;
    logic [15:0] w2, w1, w0, ck, d;
    lcap = localcnt_i;
    cyc(HDR, 1'b1, 1'b1); gap(maxgap, fixed_gap);
    if (abort_kind == 1) begin
      cyc(16'($urandom), 1'b0, 1'b1); gap(maxgap, fixed_gap);
      model_err();
      lcap = localcnt_i;
      cyc(HDR, 1'b1, 1'b1); gap(maxgap, fixed_gap);
    end
    cnt = lcap + rel;
    w2 = cnt[47:32]; w1 = cnt[31:16]; w0 = cnt[15:0];
    cyc(w2, 1'b0, 1'b1); gap(maxgap, fixed_gap);
    cyc(w1, 1'b0, 1'b1); gap(maxgap, fixed_gap);
    if (abort_kind == 2) begin
      d = 16'($urandom);
      if (d == HDR) d = d + 16'd1;
      model_err();
      cyc(d, 1'b1, 1'b1);
      check_outs("abort");
      return;
    end
    cyc(w0, 1'b0, 1'b1); gap(maxgap, fixed_gap);
    ck = w2 ^ w1 ^ w0;
    if (bad_ck) begin
      ck = ck ^ (16'd1 << $urandom_range(0, 15));
      model_err();
    end else begin
      off = cnt + linkdly_i - lcap;
      model_good(off);
      exp_stb = 1'b1;
    end
    cyc(ck, 1'b0, 1'b1);
    check_outs("frame");
  endtask

  task automatic do_reset();
    sreset_i = 1'b1;
    cyc(16'($urandom), 1'b0, 1'b0);
    sreset_i = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [47:0] base, rel;
    int r;
    sreset_i   = 1'b1;
    rxdata_i   = '0;
    rxisk_i    = 1'b0;
    rxvalid_i  = 1'b0;
    localcnt_i = 48'h1234_5678_9abc;
    linkdly_i  = 48'd20;
    exp_stb    = 1'b0;
    model_reset();
    @(negedge clk_i);
    repeat (3) cyc(16'd0, 1'b0, 1'b0);
    sreset_i = 1'b0;
    check_outs("reset");

    // Ideal link: offset 120 on every frame, lock on the 8th
    for (int i = 0; i < 8; i++) begin
      send_frame(48'd100, 1'b0, 0, 1'b0, 0);
      if (i == 6) check_eq("ideal_prelock", {47'd0, usecorr_o}, 48'd0);
      idle(3);
    end
    check_eq("ideal_usecorr",  {47'd0, usecorr_o}, 48'd1);
    check_eq("ideal_corr48",   corr48_o, 48'd120);
    check_eq("ideal_framecnt", {32'd0, framecnt_o}, 48'd8);
    check_eq("ideal_errcnt",   {32'd0, errcnt_o}, 48'd0);

    // Lock loss after ERRMAX mismatches, then requalification at 121
    for (int i = 0; i < 3; i++) send_frame(48'd101, 1'b0, 0, 1'b0, 0);
    check_eq("loss_hold_use",  {47'd0, usecorr_o}, 48'd1);
    check_eq("loss_hold_corr", corr48_o, 48'd120);
    send_frame(48'd101, 1'b0, 0, 1'b0, 0);
    check_eq("loss_drop_use",  {47'd0, usecorr_o}, 48'd0);
    for (int i = 0; i < 7; i++) send_frame(48'd101, 1'b0, 0, 1'b0, 0);
    check_eq("relock_use",  {47'd0, usecorr_o}, 48'd1);
    check_eq("relock_corr", corr48_o, 48'd121);

    // Checksum error during qualification delays lock to frame 9
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_frame(48'd100, (i == 3), 0, 1'b0, 0);
      if (i == 7) check_eq("ckerr_prelock", {47'd0, usecorr_o}, 48'd0);
      idle(1);
    end
    check_eq("ckerr_errcnt", {32'd0, errcnt_o}, 48'd1);
    check_eq("ckerr_use",    {47'd0, usecorr_o}, 48'd1);
    check_eq("ckerr_corr",   corr48_o, 48'd120);

    // Resync on a second header, then stalls of 3 cycles between words
    send_frame(48'd100, 1'b0, 0, 1'b0, 1);
    check_eq("resync_errcnt", {32'd0, errcnt_o}, 48'd2);
    check_eq("resync_offset", offset_o, 48'd120);
    send_frame(48'd100, 1'b0, 3, 1'b1, 0);
    check_eq("stall_offset", offset_o, 48'd120);

    // Counter wrap: local fff..ff0, remote 0x10, no link delay
    do_reset();
    linkdly_i  = 48'd0;
    localcnt_i = 48'hffff_ffff_fff0;
    send_frame(48'h20, 1'b0, 0, 1'b0, 0);
    check_eq("wrap_offset", offset_o, 48'h20);
    for (int i = 0; i < 7; i++) send_frame(48'h20, 1'b0, 0, 1'b0, 0);
    check_eq("wrap_use",  {47'd0, usecorr_o}, 48'd1);
    check_eq("wrap_corr", corr48_o, 48'h20);

    // Reset in the middle of a frame
    cyc(HDR, 1'b1, 1'b1);
    cyc(16'h1111, 1'b0, 1'b1);
    cyc(16'h2222, 1'b0, 1'b1);
    do_reset();
    check_outs("rstmid");
    send_frame(48'd7, 1'b0, 0, 1'b0, 0);
    check_eq("rstmid_framecnt", {32'd0, framecnt_o}, 48'd1);
    check_eq("rstmid_errcnt",   {32'd0, errcnt_o}, 48'd0);

    // Randomized traffic: jittering offsets, corruptions, aborts, gaps
    do_reset();
    linkdly_i = {16'($urandom), 32'($urandom)};
    base      = {16'($urandom), 32'($urandom)};
    for (int i = 0; i < 90; i++) begin
      if (i % 30 == 29) base = base + 48'd5;
      rel = ($urandom_range(0, 7) == 0) ? base + 48'd1 : base;
      r   = int'($urandom_range(0, 19));
      send_frame(rel, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 2)), 1'b0,
                 (r == 0) ? 1 : (r == 1) ? 2 : 0);
      idle(int'($urandom_range(0, 3)));
    end
    check_outs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icc_cnt_rx.md
Name: icc_cnt_rx

Overview:
- Receive-side counterpart of the ICC counter transmitter. Runs in the GT rxusrclk domain.
- Deframes the master's 48-bit timestamp frames from the 16-bit GT receive word stream.
- Compares each received timestamp against the local counter plus a configured link delay, and qualifies the offset over repeated frames.
- Drives corr48/usecorr toward the slave's counter-correction logic. Also reports frame and error statistics.

Parameters:
- DWIDTH, 16, GT user data width; fixed at 16 for this framing.
- HDR, 16'h5cbc, frame header word; valid only together with rxisk=1.
- LOCKCNT, 8, consecutive identical offsets required to assert usecorr.
- ERRMAX, 4, consecutive mismatching offsets while locked that drop usecorr.

Ports:
- clk  in  1  rxusrclk domain clock.
- sreset  in  1  synchronous active-high reset.
- rxdata  in  DWIDTH  received word.
- rxisk  in  1  header/comma flag for rxdata.
- rxvalid  in  1  rxdata qualifier; words with rxvalid=0 are ignored (no state advance).
- localcnt  in  48  free-running local counter, same clock.
- linkdly  in  48  calibrated link latency in counter ticks, static during lock.
- corr48  out  48  qualified offset (rxcnt+linkdly-localcnt at header), two's complement modulo 2^48.
- usecorr  out  1  corr48 qualified and in use.
- stb_corr  out  1  one-cycle pulse: new offset computed from a good frame.
- offset  out  48  offset of most recent good frame (unqualified).
- framecnt  out  16  good frames, wraps.
- errcnt  out  16  bad frames (checksum/sequence), saturates at 16'hffff.

Behaviour:
Frame format:
- HDR (rxisk=1), W2=cnt[47:32], W1=cnt[31:16], W0=cnt[15:0], CK=W2^W1^W0; all four payload words have rxisk=0.
- Only cycles with rxvalid=1 count as frame words.

FSM states: HUNT, W2, W1, W0, CK.
- HUNT: HDR with rxisk=1 -> W2. On that cycle, capture lcap=localcnt.
- W2, W1, W0: store the word -> next state.
- Any rxisk=1 in W2..CK: abort, errcnt+1.
  - If that word equals HDR, re-capture lcap and go to W2 (resync). Otherwise go to HUNT.
- CK: word==checksum -> good frame, else errcnt+1. Return to HUNT in either case.

Offset datapath:
- Good frame: offset <= {W2,W1,W0} + linkdly - lcap, modulo 2^48 (wrap-around is ordinary, not an error).
- Latency: offset/framecnt update and stb_corr pulse on the cycle after the CK word is accepted.

Qualification (on each good frame, same cycle as stb_corr):
- agree counter: if new offset == previous good offset, agree = min(agree+1, LOCKCNT); else agree = 0.
- Unlocked and agree reaches LOCKCNT-1 on this frame (i.e., LOCKCNT identical offsets seen): usecorr <= 1, corr48 <= offset.
- Locked, offset == corr48: mismatch counter cleared.
- Locked, offset != corr48: mismatch+1, corr48 held.
  - When mismatch reaches ERRMAX: usecorr <= 0, agree <= 0, mismatch <= 0, and re-qualification starts from this frame's offset.
- Bad frames do not touch agree, mismatch, offset, or corr48.

Reset (sreset=1, takes effect at next edge, overrides everything, including mid-frame):
- state=HUNT; corr48=0; offset=0; usecorr=0; stb_corr=0; framecnt=0; errcnt=0; agree=0; mismatch=0; lcap=0.
- A frame partly received at reset is discarded without an error count.

Simultaneous events:
- rxvalid=0 inside a frame holds the state (no timeout).
- HDR arriving on the cycle stb_corr fires is accepted normally (back-to-back frames supported at 5-word spacing).

Test Plan:
- Ideal link: frames every 8 cycles, cnt=localcnt_at_hdr+100, linkdly=20 -> offset=120 each frame; usecorr rises on stb_corr of frame 8, corr48=120; framecnt=8, errcnt=0.
- Wrap: localcnt=48'hffff_ffff_fff0, cnt=48'h10, linkdly=0 -> offset=48'h20; after 8 frames corr48=48'h20, usecorr=1.
- Checksum error: corrupt CK of frame 4 during qualification -> errcnt=1, no stb_corr for frame 4; lock reached on frame 9, offset stream unaffected.
- Lock loss: locked at corr48=120, then 3 frames at offset 121 -> usecorr stays 1, corr48=120. The 4th mismatching frame -> usecorr=0. 7 further 121-frames (8 total counting the 4th) -> usecorr=1, corr48=121.
- Resync and stalls: HDR, W2, then HDR again -> errcnt+1, new frame completes good with lcap from the second HDR. rxvalid gaps of 3 cycles between words -> same offset as with no gaps.
- Reset mid-frame: sreset pulse after W1 -> all outputs 0, errcnt=0, no stb_corr; next complete frame is good with framecnt=1.
